// File: rtl/rng_postproc.sv
// -----------------------------------------------------------------------------
// rng_postproc
//
// Post-processing for the 8-bit ring-oscillator XOR sampler.
//   - Owns the oscillator enable and steps through IDLE -> WARMUP -> RUN, with
//     FAULT entered when the repetition-count health test trips.
//   - Registers each raw sample and checks it with a repetition-count test.
//   - Removes bias with a von Neumann corrector over the four bit pairs.
//   - Packs the resulting bits LSB-first into bytes.
//   - Buffers the bytes in a show-ahead FIFO with a valid/ready interface.
//
// Pipeline: raw_in is registered into raw_q (edge N). The health test and the
// debias step are registered next (edge N+1). The pack step and FIFO push
// happen at edge N+2, so a completed byte shows on rnd_valid after edge N+2.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   level request to generate random bytes
//   clear_fail   in   pulse: clears health_fail/overflow and leaves FAULT
//   ro_en        out  enable to the oscillator sampler
//   raw_in[7:0]  in   registered XOR byte from the sampler
//   rnd_data     out  head of the output FIFO (0 when empty)
//   rnd_valid    out  FIFO not empty
//   rnd_ready    in   consumer accepts rnd_data when rnd_valid && rnd_ready
//   health_fail  out  sticky repetition-test failure
//   overflow     out  sticky: a completed byte was dropped (FIFO full)
// -----------------------------------------------------------------------------
module rng_postproc #(
    parameter int WARMUP_CYCLES = 16,
    parameter int REP_LIMIT     = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear_fail,
    output logic       ro_en,
    input  logic [7:0] raw_in,
    output logic [7:0] rnd_data,
    output logic       rnd_valid,
    input  logic       rnd_ready,
    output logic       health_fail,
    output logic       overflow
);

    localparam int WU_W  = $clog2(WARMUP_CYCLES + 1);
    localparam int REP_W = $clog2(REP_LIMIT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAULT} state_t;

    // Von Neumann corrector: returns {count[2:0], bits[3:0]}.
    // Pairs are examined (b1,b0), (b3,b2), (b5,b4), (b7,b6); a pair "10" gives 1
    // and "01" gives 0, so the emitted bit is the upper bit of an unequal pair.
    function automatic logic [6:0] debias(input logic [7:0] s);
        logic [3:0] bits;
        logic [2:0] n;
        bits = '0;
        n    = '0;
        for (int p = 0; p < 4; p++) begin
            if (s[2*p+1] != s[2*p]) begin
                bits[n[1:0]] = s[2*p+1];
                n            = n + 3'd1;
            end
        end
        return {n, bits};
    endfunction

    // Control state
    state_t             state_q, state_d;
    logic               ro_en_q, ro_en_d;
    logic [WU_W-1:0]    wu_cnt_q, wu_cnt_d;
    logic               raw_vld_q, raw_vld_d;
    logic               raw_first_q, raw_first_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               db_vld_q, db_vld_d;
    logic [2:0]         acc_cnt_q, acc_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               health_fail_q, health_fail_d;
    logic               overflow_q, overflow_d;

    // Datapath state (qualified by the control flags above, so not reset)
    logic [7:0]         raw_q, raw_d;
    logic [7:0]         prev_raw_q, prev_raw_d;
    logic [3:0]         db_bits_q, db_bits_d;
    logic [2:0]         db_n_q, db_n_d;
    logic [11:0]        acc_q, acc_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    // Combinational helpers
    logic               s1_go, rep_trip;
    logic               s2_go, byte_done, full, pop, push, drop, flush;
    logic [11:0]        merged;
    logic [3:0]         sum;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ro_en_q  <= 1'b0;
            wu_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ro_en_q  <= ro_en_d;
            wu_cnt_q <= wu_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d  = state_q;
        wu_cnt_d = wu_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d  = S_WARMUP;
                    wu_cnt_d = WU_W'(WARMUP_CYCLES);
                end
            end
            S_WARMUP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    wu_cnt_d = wu_cnt_q - WU_W'(1);
                    // The decrement to zero happens on this edge, so RUN
                    // starts exactly WARMUP_CYCLES cycles after ro_en rose.
                    if (wu_cnt_q <= WU_W'(1)) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rep_trip)     state_d = S_FAULT;
                else if (!enable) state_d = S_IDLE;
            end
            S_FAULT: begin
                if (clear_fail) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        // ro_en is registered from the next state so it lines up with the state.
        ro_en_d       = (state_d == S_WARMUP) || (state_d == S_RUN);
        health_fail_d = health_fail_q;
        if (rep_trip)        health_fail_d = 1'b1;
        else if (clear_fail) health_fail_d = 1'b0;
        overflow_d = overflow_q;
        if (drop)            overflow_d = 1'b1;
        else if (clear_fail) overflow_d = 1'b0;
    end

    // ---------------- Stage 1: health test and debias ----------------
    always_comb begin
        raw_d       = raw_in;
        raw_vld_d   = (state_q == S_RUN);
        // First sample of a RUN period: the previous cycle was not RUN.
        raw_first_d = (state_q == S_RUN) && !raw_vld_q;
        s1_go       = raw_vld_q && (state_q == S_RUN);
        rep_cnt_d   = rep_cnt_q;
        prev_raw_d  = prev_raw_q;
        if (s1_go) begin
            prev_raw_d = raw_q;
            if (raw_first_q || (raw_q != prev_raw_q)) rep_cnt_d = REP_W'(1);
            else                                      rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
        rep_trip            = s1_go && (rep_cnt_d == REP_W'(REP_LIMIT));
        {db_n_d, db_bits_d} = debias(raw_q);
        // A sample that trips the test contributes no bits.
        db_vld_d            = s1_go && !rep_trip;
    end

    // ---------------- Stage 2: pack and FIFO ----------------
    always_comb begin
        pop       = rnd_valid && rnd_ready;
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        s2_go     = db_vld_q && (state_q == S_RUN);
        merged    = acc_q | (12'(db_bits_q) << acc_cnt_q);
        sum       = {1'b0, acc_cnt_q} + {1'b0, db_n_q};
        byte_done = s2_go && sum[3];
        flush     = (state_q == S_FAULT) || (state_d == S_FAULT);
        // A full FIFO still takes the byte if the head leaves this cycle.
        push      = byte_done && (!full || pop) && !flush;
        drop      = byte_done && full && !pop && !flush;

        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        if (state_q != S_RUN) begin
            acc_d     = '0;
            acc_cnt_d = '0;
        end else if (s2_go) begin
            // The remainder shifts down whether the byte was stored or dropped;
            // sum[2:0] equals sum-8 whenever a byte completes.
            acc_d     = byte_done ? (merged >> 8) : merged;
            acc_cnt_d = sum[2:0];
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_vld_q     <= 1'b0;
            raw_first_q   <= 1'b0;
            rep_cnt_q     <= '0;
            db_vld_q      <= 1'b0;
            acc_cnt_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            health_fail_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            raw_vld_q     <= raw_vld_d;
            raw_first_q   <= raw_first_d;
            rep_cnt_q     <= rep_cnt_d;
            db_vld_q      <= db_vld_d;
            acc_cnt_q     <= acc_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            health_fail_q <= health_fail_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        raw_q      <= raw_d;
        prev_raw_q <= prev_raw_d;
        db_bits_q  <= db_bits_d;
        db_n_q     <= db_n_d;
        acc_q      <= acc_d;
        if (push) mem_q[wr_ptr_q] <= merged[7:0];
    end

    assign ro_en       = ro_en_q;
    assign rnd_valid   = (count_q != '0);
    assign rnd_data    = rnd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign health_fail = health_fail_q;
    assign overflow    = overflow_q;

endmodule
